// File: rtl/seq_divider_32_pkg.sv
// Shared constants and helpers for the sequential 32-bit divider.
package seq_divider_32_pkg;

  localparam int WIDTH = 32;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  // One quotient bit is produced per ITER cycle
  localparam int DIV_STEPS = 32;

  // Quotient reported on a zero divisor
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Two's complement negation modulo 2^32
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of a signed value; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_32_if.sv
// Request/result bundle between the control unit and the divider.
// Handshake: start is a request that is accepted only while the divider
// is idle (busy low); operands and div_signed are captured on that edge.
// busy stays high until the result edge, where done pulses for one cycle
// and quotient/remainder/div_by_zero become valid and are held until the
// next done. A start during busy is dropped, never queued.
interface seq_divider_32_if;
  import seq_divider_32_pkg::*;

  logic             start;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, div_signed, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, div_signed, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/seq_divider_32_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups joined by a
// group-level generate/propagate chain.
module CLA_32bit_adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout,
  output logic        G_prime,
  output logic        P_prime
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [7:0]  w_gg;
  logic [7:0]  w_gp;
  logic [8:0]  w_gc;
  logic        w_gacc;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Group generate/propagate, group carries, then per-bit lookahead carries
  always_comb begin
    w_gg   = '0;
    w_gp   = '0;
    w_gc   = '0;
    w_c    = '0;
    w_gacc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
    w_gc[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
      w_gacc    = w_gg[k] | (w_gp[k] & w_gacc);
    end
    for (int k = 0; k < 8; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign Sum     = w_p ^ w_c;
  assign Cout    = w_gc[8];
  assign G_prime = w_gacc;
  assign P_prime = &w_gp;

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle non-restoring 32-bit divider (DIV/DIVU). One CLA adder pass
// per cycle; remainder goes to HI, quotient to LO.
module seq_divider_32
  import seq_divider_32_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  seq_divider_32_if.slave        bus,
  output logic [1:0]             o_dbg_state
);

  logic [1:0]  r_state;
  logic        r_signed;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [32:0] r_r;
  logic [31:0] r_q;
  logic [31:0] r_d;
  logic [4:0]  r_count;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic [31:0] r_quot;
  logic [31:0] r_rem;

  logic        w_fix;
  logic [32:0] w_rs;
  logic        w_sub;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_cin;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_rnew_msb;
  logic [31:0] w_r_final;

  // ITER shifts the next dividend bit in and subtracts (R >= 0) or adds
  // (R < 0) the divisor; FIX reuses the adder as R + D for the restore.
  assign w_fix = (r_state == FIX);
  assign w_rs  = {r_r[31:0], r_q[31]};
  assign w_sub = !w_fix && !r_r[32];
  assign w_a   = w_fix ? r_r[31:0] : w_rs[31:0];
  assign w_b   = w_sub ? ~r_d : r_d;
  assign w_cin = w_sub;

  CLA_32bit_adder u_cla (
    .A       (w_a),
    .B       (w_b),
    .Cin     (w_cin),
    .Sum     (w_sum),
    .Cout    (w_cout),
    .G_prime (),
    .P_prime ()
  );

  // Sign of the 33-bit partial remainder, from the 32-bit adder carry
  assign w_rnew_msb = w_rs[32] ^ w_sub ^ w_cout;
  assign w_r_final  = r_r[32] ? w_sum : r_r[31:0];

  // Division FSM and datapath registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_signed   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_r        <= '0;
      r_q        <= '0;
      r_d        <= '0;
      r_count    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_signed   <= bus.div_signed;
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
            r_busy     <= 1'b1;
            r_dbz      <= 1'b0;
            r_state    <= PREP;
          end
        end
        PREP: begin
          if (r_divisor == '0) begin
            r_quot  <= DIV_ZERO_QUOT;
            r_rem   <= r_dividend;
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_r     <= '0;
            r_q     <= r_signed ? abs32(r_dividend) : r_dividend;
            r_d     <= r_signed ? abs32(r_divisor) : r_divisor;
            r_neg_q <= r_signed & (r_dividend[31] ^ r_divisor[31]);
            r_neg_r <= r_signed & r_dividend[31];
            r_count <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_r     <= {w_rnew_msb, w_sum};
          r_q     <= {r_q[30:0], ~w_rnew_msb};
          r_count <= r_count + 5'd1;
          if (r_count == 5'(DIV_STEPS - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quot  <= r_neg_q ? neg32(r_q) : r_q;
          r_rem   <= r_neg_r ? neg32(w_r_final) : w_r_final;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed and random stimulus for seq_divider_32 with a result scoreboard.
module tb_seq_divider_32;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] dbg_state;

  seq_divider_32_if bus ();

  seq_divider_32 dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {div_by_zero, quotient, remainder}
  logic [64:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model, written from the arithmetic definition
  function automatic logic [64:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Drive start for one cycle; called at #1 after a rising edge and
  // returns at #1 after the start-sampling edge
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [64:0] e);
    bus.start      = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, check latency and busy length, then score.
  // mode 1 pulses start at cycle 5 and changes operands at cycle 6.
  task automatic wait_done(input int exp_lat, input int exp_busy, input int mode);
    int lat;
    int bcnt;
    logic [64:0] e;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) bcnt++;
      if (mode == 1 && lat == 5) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
      end
      if (mode == 1 && lat == 6) begin
        bus.start      = 1'b0;
        bus.dividend   = 32'd77;
        bus.divisor    = 32'd9;
        bus.div_signed = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(bcnt), 64'(exp_busy));
    chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(e[64]));
      chk("quotient", 64'(bus.quotient), 64'(e[63:32]));
      chk("remainder", 64'(bus.remainder), 64'(e[31:0]));
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int dones;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk(tag, 64'(dones), 64'd0);
  endtask

  task automatic done_low_next;
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    bus.start      = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;

    // Reset
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_quot", 64'(bus.quotient), 64'd0);
    chk("rst_rem", 64'(bus.remainder), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned 100 / 7
    start_op(1'b0, 32'd100, 32'd7, 1'b1, {1'b0, 32'd14, 32'd2});
    wait_done(34, 34, 0);
    done_low_next();

    // Signed -7 / 2
    start_op(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b1, {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    wait_done(34, 34, 0);
    done_low_next();

    // Unsigned 0xFFFFFFFF / 1
    start_op(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, {1'b0, 32'hFFFF_FFFF, 32'h0});
    wait_done(34, 34, 0);
    done_low_next();

    // Signed overflow case wraps
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'h8000_0000, 32'h0});
    wait_done(34, 34, 0);
    done_low_next();

    // Signed 7 / -2
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, {1'b0, 32'hFFFF_FFFD, 32'd1});
    wait_done(34, 34, 0);
    done_low_next();

    // Divide by zero
    start_op(1'b0, 32'd5, 32'd0, 1'b1, {1'b1, 32'hFFFF_FFFF, 32'd5});
    wait_done(1, 1, 0);
    done_low_next();
    chk("dbz_held", 64'(bus.div_by_zero), 64'd1);

    // Next start clears div_by_zero
    start_op(1'b0, 32'd9, 32'd4, 1'b1, {1'b0, 32'd2, 32'd1});
    chk("dbz_cleared", 64'(bus.div_by_zero), 64'd0);
    wait_done(34, 34, 0);

    // Back-to-back: start issued while done is high
    start_op(1'b0, 32'd20, 32'd6, 1'b1, {1'b0, 32'd3, 32'd2});
    chk("b2b_done_low", 64'(bus.done), 64'd0);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(34, 34, 0);
    done_low_next();

    // Start while busy is ignored; operand changes have no effect
    start_op(1'b0, 32'd1000, 32'd3, 1'b1, {1'b0, 32'd333, 32'd1});
    wait_done(34, 34, 1);
    expect_no_done("no_extra_done", 40);

    // Abort with clr in flight
    start_op(1'b0, 32'd1000, 32'd3, 1'b0, '0);
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_quot", 64'(bus.quotient), 64'd0);
    chk("abort_rem", 64'(bus.remainder), 64'd0);
    chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    expect_no_done("abort_no_done", 40);
    start_op(1'b0, 32'd9, 32'd4, 1'b1, {1'b0, 32'd2, 32'd1});
    wait_done(34, 34, 0);
    done_low_next();

    // Random operands against the model
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      if (i == 3) rb = 32'($urandom_range(0, 20)) - 32'd10;
      if (rb == 32'd0) rb = 32'hFFFF_FFF0;
      start_op(rs, ra, rb, 1'b1, model(rs, ra, rb));
      wait_done(34, 34, 0);
    end

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_32.md
Name: seq_divider_32

Overview:
Multi-cycle 32-bit integer divider for the DIV/DIVU instructions, built on the 32-bit CLA adder.
- Runs non-restoring division, one adder pass per cycle: it feeds the adder its operands and consumes its sum/carry.
- Results feed the Z register: remainder goes to ZHigh/HI, quotient goes to ZLow/LO.
- The control unit holds the datapath in its DIV step until done.

Parameters:
WIDTH, 32, operand width; only 32 is supported because the CLA adder is fixed at 32 bits.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous active-high reset
start  input  1  request a division; sampled only in IDLE
div_signed  input  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start
dividend  input  32  numerator; sampled on the start edge
divisor  input  32  denominator; sampled on the start edge
busy  output  1  high from the edge after start is accepted until done is raised
done  output  1  one-cycle pulse; results are valid from this cycle on
div_by_zero  output  1  set with done when divisor == 0; cleared on the next accepted start
quotient  output  32  quotient; held until the next done
remainder  output  32  remainder; held until the next done

Behaviour:
- Reset: when clr is high at an edge, state <= IDLE and busy, done, div_by_zero, quotient, remainder <= 0, regardless of current state. An operation in flight is aborted and produces no done.
- State machine: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 latches div_signed, dividend and divisor, sets busy=1 and goes to PREP.
  - start=0 stays in IDLE.
  - start while busy is ignored; it is not queued.
- PREP:
  - If divisor == 0: quotient <= 32'hFFFFFFFF, remainder <= dividend, div_by_zero <= 1, done <= 1, busy <= 0, go to IDLE. Latency is 1 edge after the start edge.
  - Otherwise: sign handling and register loads below, then go to ITER.
    - Signed mode: load |dividend| and |divisor|. neg_q = sign(dividend) XOR sign(divisor). neg_r = sign(dividend).
    - Unsigned mode: load operands unchanged, neg_q = neg_r = 0.
    - Registers: R (33-bit) <= 0, Q <= |dividend|, D <= |divisor|, count <= 0.
- ITER, 32 cycles, one step per cycle:
  - Shift: Rs = {R[31:0], Q[31]}.
  - If R[32]==0: R <= Rs - D, via adder A=Rs[31:0], B=~D, Cin=1. Otherwise: R <= Rs + D, via A=Rs[31:0], B=D, Cin=0.
  - R[32] = Rs[32] XOR B-extension bit XOR adder C_out. The B-extension bit is 1 for subtract, 0 for add.
  - Q <= {Q[30:0], ~Rnew[32]}. count++.
  - After the 32nd step (count==31), go to FIX.
- FIX, 1 cycle:
  - If R[32]==1, restore R <= R + D using the same adder.
  - quotient <= neg_q ? -Q : Q. remainder <= neg_r ? -R[31:0] : R[31:0].
  - done <= 1, busy <= 0, go to IDLE.
  - Negation is two's complement modulo 2^32.
- Normal latency: 34 edges from the start-sampling edge to the edge that raises done. busy is high for exactly 34 cycles.
- Edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000, remainder 0, with no overflow flag.
  - Remainder always carries the sign of the dividend, or is zero.
- done deasserts on the following edge. A start sampled in the cycle done is high is accepted normally.
- Output changes on dividend/divisor/div_signed while busy have no effect.

Decomposition:
- Shared package/header holds:
  - the state encodings IDLE=2'd0, PREP=2'd1, ITER=2'd2, FIX=2'd3;
  - the iteration count constant DIV_STEPS=32;
  - the divide-by-zero quotient constant 32'hFFFFFFFF.
- One sub-module: CLA_32bit_adder, instantiated once.
  - It is shared by ITER and FIX, with an operand mux on B/Cin.
  - Its G_prime/P_prime outputs are left unconnected.
- Sign/abs negation uses small local negate logic, not a second adder.

Test Plan:
- Unsigned 100 / 7, start for one cycle -> done exactly 34 edges later; quotient=14, remainder=2, div_by_zero=0, busy high for 34 cycles.
- Signed -7 / 2 (32'hFFFFFFF9, 32'h2) -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF; unsigned 32'hFFFFFFFF / 1 -> quotient=32'hFFFFFFFF, remainder=0.
- Signed 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0; signed 7 / -2 -> quotient=32'hFFFFFFFD, remainder=1.
- Divide by zero, 5 / 0 -> done one edge after the start edge, div_by_zero=1, quotient=32'hFFFFFFFF, remainder=5; next valid start clears div_by_zero.
- Start 1000 / 3, pulse start again at cycle 5, change operands at cycle 6 -> single done at edge 34, quotient=333, remainder=1.
- Start 1000 / 3, assert clr at cycle 10 -> next cycle busy=0, all outputs 0, no done within 40 cycles; a new start 9 / 4 then gives quotient=2, remainder=1.
